// File: rtl/score_display_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : score_display_mux_if
// Brief    : Load/status/display bundle between a score source and the mux.
// Revision : 1.0
// ============================================================================
interface score_display_mux_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_WIDTH = 14
);
  logic [VALUE_WIDTH-1:0] value;
  logic                   load;
  logic                   busy;
  logic                   overflow;
  logic [6:0]             seg;
  logic [NUM_DIGITS-1:0]  an;

  modport master (output value, load, input busy, overflow, seg, an);
  modport slave  (input value, load, output busy, overflow, seg, an);
endinterface
`default_nettype wire

// File: rtl/score_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : score_display_mux
// Brief    : Sequential binary-to-BCD converter with multiplexed 7-seg scan.
//            Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Revision : 1.0
// ============================================================================
module score_display_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_WIDTH   = 14,
  parameter int SCAN_DIV      = 50000,
  parameter int INVERT_OUTPUT = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  score_display_mux_if.slave bus
);

  localparam int c_BCD_W = 4 * NUM_DIGITS;
  localparam int c_CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam int c_DIV_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic c_INV = (INVERT_OUTPUT != 0);

  function automatic logic [63:0] f_max_val();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < NUM_DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] c_MAX_VAL = f_max_val();
  localparam logic [6:0]  c_SEG_RST = 7'b0111111 ^ {7{c_INV}};
  localparam logic [NUM_DIGITS-1:0] c_AN_RST =
    NUM_DIGITS'(1) ^ {NUM_DIGITS{c_INV}};

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2} state_t;

  state_t                 r_state;
  logic [VALUE_WIDTH-1:0] r_bin;
  logic [c_BCD_W-1:0]     r_bcd;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_ovf_pend;
  logic                   r_overflow;
  logic                   r_busy;
  logic [c_BCD_W-1:0]     r_digits;
  logic [c_DIV_W-1:0]     r_div;
  logic [c_IDX_W-1:0]     r_idx;
  logic [6:0]             r_seg;
  logic [NUM_DIGITS-1:0]  r_an;

  logic [c_BCD_W-1:0]     w_adj;
  logic [NUM_DIGITS-1:0]  w_blank;
  logic                   w_div_last;
  logic [c_IDX_W-1:0]     w_idx_nxt;
  logic [3:0]             w_digit;
  logic [6:0]             w_seg_act;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_digits   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_bin      <= bus.value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (64'(bus.value) > c_MAX_VAL);
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Carries out of the top nibble fall off; overflow masks them later.
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(VALUE_WIDTH - 1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_digits   <= r_ovf_pend ? {NUM_DIGITS{4'd9}} : r_bcd;
          r_overflow <= r_ovf_pend;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : b_blank
      logic w_zero_run;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        w_zero_run = w_zero_run && (r_digits[4*i +: 4] == 4'd0);
        w_blank[i] = w_zero_run;
      end
    end
`endif
  end

  // Outputs are built from the next index so an/seg stay aligned with r_idx.
  assign w_div_last = (r_div == c_DIV_W'(SCAN_DIV - 1));
  assign w_idx_nxt  = !w_div_last ? r_idx :
                      (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
  assign w_digit    = r_digits[w_idx_nxt*4 +: 4];
  assign w_seg_act  = w_blank[w_idx_nxt] ? 7'b0000000 : f_seg(w_digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
      r_seg <= c_SEG_RST;
      r_an  <= c_AN_RST;
    end else begin
      r_div <= w_div_last ? '0 : r_div + 1'b1;
      r_idx <= w_idx_nxt;
      r_seg <= w_seg_act ^ {7{c_INV}};
      r_an  <= (NUM_DIGITS'(1) << w_idx_nxt) ^ {NUM_DIGITS{c_INV}};
    end
  end

  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;
  assign bus.seg      = r_seg;
  assign bus.an       = r_an;

endmodule
`default_nettype wire

// File: doc/score_display_mux.md
# score_display_mux

Multi-digit, time-multiplexed 7-segment driver for the score and status readouts. It accepts a binary value and converts it to BCD sequentially (shift-add-3), one bit per clock. It then scans the resulting digits across a common-segment display, one digit at a time. It generalises the single-digit decoder with parametrised digit count and value width, continuous scanning, busy/overflow reporting, and optional leading-zero blanking.

## Interface
- NUM_DIGITS, 4: number of display digits (1–8).
- VALUE_WIDTH, 14: width of the binary input value (1–27).
- SCAN_DIV, 50000: clocks per digit dwell period (≥2).
- INVERT_OUTPUT, 1: 1 = segments and digit enables are active-low; 0 = active-high.

Ports:
- clk  in  1: system clock, all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- value  in  VALUE_WIDTH: binary value to display, sampled on accepted load.
- load  in  1: single-cycle request to convert `value`.
- busy  out  1: conversion in progress; load ignored while high.
- overflow  out  1: last committed value exceeded 10^NUM_DIGITS−1.
- seg  out  7: segments {g,f,e,d,c,b,a}, registered.
- an  out  NUM_DIGITS: one-hot digit enable, bit 0 = least significant digit, registered.

## Operation
- Segment encoding (active-high, before inversion):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - blank=0000000
- With INVERT_OUTPUT=1, both seg and an are the bitwise complement of the active-high values.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: load=1 captures `value` into the shift register, clears the BCD accumulator and the bit counter, evaluates overflow (value > 10^NUM_DIGITS−1), and moves to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1. Stays for VALUE_WIDTH cycles, then moves to COMMIT.
  - COMMIT: copies the BCD accumulator into the display digit registers and updates `overflow`. If overflow, all digits are forced to 9. Returns to IDLE.
- BCD accumulator width is 4·NUM_DIGITS. Carries beyond the top nibble are discarded, which is harmless because overflow forces 9s.
- load while busy: ignored; no queuing.
- load and reset in the same cycle: reset wins.
- The display registers hold the last committed digits indefinitely. The scan never stalls during conversion.
- Scanner:
  - Dwell counter runs 0..SCAN_DIV−1.
  - At terminal count, the counter wraps to 0 and the digit index advances, wrapping NUM_DIGITS−1 → 0.
  - seg/an register the encoding of the indexed digit and its one-hot enable.
- Reset:
  - State IDLE, busy=0, overflow=0, all digits 0, dwell counter 0, digit index 0.
  - seg = encoding of 0 (1000000 when inverted).
  - an = digit 0 enabled (…1110 when inverted).

## Timing
- Edge E0: load accepted, busy=1 from E0 onward.
- Edges E1..E(VALUE_WIDTH): shifts.
- Edge E(VALUE_WIDTH+1): commit, busy=0. busy is high for exactly VALUE_WIDTH+1 cycles.
- A new load is accepted in the cycle busy reads 0.
- seg/an reflect the new digits one clock after commit, for whichever digit is currently indexed.
- Each digit is enabled for exactly SCAN_DIV clocks. The full refresh period is NUM_DIGITS·SCAN_DIV clocks.
- seg and an change on the same edge, so no mixed digit/segment cycle is allowed.
- Reset mid-conversion: the next cycle is IDLE with reset values, and the previously displayed digits are cleared to 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i>0 shows blank when it and all more-significant digits are 0. Digit 0 is never blanked, so value 0 shows "0" and value 7 on 4 digits shows "   7". Overflow 9s are never blanked.
- Undefined: all digits are always displayed, so value 7 shows "0007".

## Test plan
Bench uses NUM_DIGITS=4, VALUE_WIDTH=14, SCAN_DIV=4, INVERT_OUTPUT=1.
- Reset release → seg=1000000, an=1110; an rotates 1110→1101→1011→0111→1110 every 4 clocks; busy=0, overflow=0.
- load with value=1234 → busy high exactly 15 cycles; afterwards digits 0..3 show 4,3,2,1 (seg=~1100110, ~1001111, ~1011011, ~0000110); overflow=0.
- load with value=12000 → all digits show 9 (seg=~1101111 = 0010000); overflow=1. Then load 0 → overflow=0, digit0 shows "0".
- load with value=7, macro defined → digit0 seg=~0000111, digits 1–3 seg=1111111 (blank). Without the macro → digits 1–3 seg=1000000.
- Second load 3 cycles into a conversion of 55 (second value 99) → ignored, display shows 55, busy timing unchanged. Load 99 immediately after busy falls → accepted.
- Reset asserted 5 cycles into a conversion of 9999 → busy=0 next cycle, digits 0, no commit of 9999.
